// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared sign-magnitude max rule, lane slicing and sizing helpers for max_pool_2d
package pool_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_POOL       = 2;
    localparam int DEF_IMG_W      = 28;
    localparam int DEF_IMG_H      = 28;

    // Counter width for a 0..n-1 counter; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lane_lsb(input int c, input int dw);
        return c * dw;
    endfunction

    // True when a wins the sign-magnitude max against b; operands are dw bits, zero-extended.
    function automatic logic sm_a_wins(input logic [63:0] a, input logic [63:0] b, input int dw);
        logic [63:0] sbit;
        logic [63:0] mask;
        logic        sa;
        logic        sb;
        sbit = 64'd1 << (dw - 1);
        mask = sbit - 64'd1;
        sa   = |(a & sbit);
        sb   = |(b & sbit);
        if (sa != sb) begin
            return !sa;
        end
        if (!sa) begin
            return (a & mask) >= (b & mask);
        end
        return (a & mask) <= (b & mask);
    endfunction

endpackage

// File: rtl/sm_max.sv
// rtl/sm_max.sv - combinational two-input sign-magnitude max for one lane
module sm_max
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] y
);

    always_comb begin
        y = sm_a_wins(64'(a), 64'(b), DATA_WIDTH) ? a : b;
    end

endmodule

// File: rtl/max_pool_2d.sv
// rtl/max_pool_2d.sv - streaming POOLxPOOL stride-POOL max pooling over a row-major multi-lane pixel stream
module max_pool_2d
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int POOL       = DEF_POOL,
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
    output logic                           out_last
);

    localparam int OUT_W = IMG_W / POOL;
    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);
    localparam int IDX_W = cnt_w(OUT_W);
    localparam int K_W   = cnt_w(POOL);
    localparam int BUS_W = CHANNELS * DATA_WIDTH;
    localparam logic [K_W-1:0]   K_MAX   = K_W'(POOL - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 1);

    // kc/kr/idx are kept as their own counters so no divider is needed.
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [K_W-1:0]   kc_q, kc_d, kr_q, kr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [BUS_W-1:0] hacc_q, hacc_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [BUS_W-1:0] out_data_q, out_data_d;

    logic [BUS_W-1:0] rbuf_q [OUT_W];
    logic [BUS_W-1:0] rbuf_rd;
    logic [BUS_W-1:0] rbuf_wdata;
    logic             rbuf_we;
    logic [BUS_W-1:0] h_bus;
    logic [BUS_W-1:0] v_bus;
    logic             accept;

    assign rbuf_rd = rbuf_q[idx_q];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        sm_max #(.DATA_WIDTH(DATA_WIDTH)) u_hmax (
            .a (hacc_q[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
            .b (in_data[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
            .y (h_bus[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH])
        );
        sm_max #(.DATA_WIDTH(DATA_WIDTH)) u_vmax (
            .a (rbuf_rd[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
            .b (h_bus[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH]),
            .y (v_bus[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

    assign in_ready  = !out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        kc_d        = kc_q;
        kr_d        = kr_q;
        idx_d       = idx_q;
        hacc_d      = hacc_q;
        out_valid_d = out_valid_q & !out_ready;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        rbuf_we     = 1'b0;
        rbuf_wdata  = h_bus;
        if (accept) begin
            hacc_d = (kc_q == '0) ? in_data : h_bus;
            if (col_q == COL_MAX) begin
                col_d = '0;
                kc_d  = '0;
                idx_d = '0;
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                    kr_d  = '0;
                end else begin
                    row_d = row_q + ROW_W'(1);
                    kr_d  = (kr_q == K_MAX) ? '0 : kr_q + K_W'(1);
                end
            end else begin
                col_d = col_q + COL_W'(1);
                if (kc_q == K_MAX) begin
                    kc_d  = '0;
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    kc_d = kc_q + K_W'(1);
                end
            end
            if (kc_q == K_MAX) begin
                if (kr_q == K_MAX) begin
                    out_valid_d = 1'b1;
                    out_data_d  = v_bus;
                    out_last_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
                end else begin
                    rbuf_we    = 1'b1;
                    rbuf_wdata = (kr_q == '0) ? h_bus : v_bus;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            kc_q        <= '0;
            kr_q        <= '0;
            idx_q       <= '0;
            hacc_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            kc_q        <= kc_d;
            kr_q        <= kr_d;
            idx_q       <= idx_d;
            hacc_q      <= hacc_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    // Row buffer holds no reset: row 0 of every frame overwrites it.
    always_ff @(posedge clk) begin
        if (rbuf_we) begin
            rbuf_q[idx_q] <= rbuf_wdata;
        end
    end

endmodule

// File: tb/tb_max_pool_2d.sv
// tb/tb_max_pool_2d.sv - self-checking bench for max_pool_2d (4x4 POOL=2 four-lane and 6x6 POOL=3 single-lane)
module tb_max_pool_2d;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [63:0] a_in_data, a_out_data;
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
    logic [15:0] c_in_data, c_out_data;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] pix [4][36];
    logic [15:0] model_out [4][9];
    logic [64:0] exp_a [$];
    logic [64:0] exp_c [$];
    int          rdy_mode = 0;
    int          got_a = 0;
    int          got_c = 0;

    max_pool_2d #(.DATA_WIDTH(16), .CHANNELS(4), .POOL(2), .IMG_W(4), .IMG_H(4)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last)
    );

    max_pool_2d #(.DATA_WIDTH(16), .CHANNELS(1), .POOL(3), .IMG_W(6), .IMG_H(6)) u_c (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (c_in_valid),
        .in_ready  (c_in_ready),
        .in_data   (c_in_data),
        .out_valid (c_out_valid),
        .out_ready (c_out_ready),
        .out_data  (c_out_data),
        .out_last  (c_out_last)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ordering key: -m..-1 < -0 < +0 < +1..+m
    function automatic int sm_key(input logic [15:0] v);
        int m;
        m = int'(v[14:0]);
        return v[15] ? -2 * m : 2 * m + 1;
    endfunction

    // Golden model: max over each window of the frame held in pix, pushed in emission order.
    task automatic model(input int w, input int h, input int p, input int nch, input bit to_c);
        int          nwin;
        logic [15:0] best;
        logic [15:0] v;
        logic [63:0] d;
        logic        last;
        nwin = 0;
        for (int wr = 0; wr < h / p; wr++) begin
            for (int wc = 0; wc < w / p; wc++) begin
                d = '0;
                for (int l = 0; l < nch; l++) begin
                    best = pix[l][wr * p * w + wc * p];
                    for (int dy = 0; dy < p; dy++) begin
                        for (int dx = 0; dx < p; dx++) begin
                            v = pix[l][(wr * p + dy) * w + wc * p + dx];
                            if (sm_key(v) > sm_key(best)) best = v;
                        end
                    end
                    model_out[l][nwin] = best;
                    d[l * 16 +: 16] = best;
                end
                last = (wr == h / p - 1) && (wc == w / p - 1);
                if (to_c) exp_c.push_back({last, d});
                else exp_a.push_back({last, d});
                nwin++;
            end
        end
    endtask

    task automatic drive_a(input int nb, input int bub);
        int i;
        int guard;
        logic acc;
        i = 0;
        guard = 0;
        while (i < nb) begin
            if (bub > 0 && $urandom_range(99) < bub) begin
                a_in_valid = 1'b0;
                a_in_data  = {$urandom, $urandom};
                @(posedge clk);
                #1;
            end else begin
                a_in_valid = 1'b1;
                a_in_data  = {pix[3][i], pix[2][i], pix[1][i], pix[0][i]};
                @(negedge clk);
                acc = a_in_ready;
                @(posedge clk);
                #1;
                if (acc) i++;
            end
            guard++;
            if (guard > 3000) begin
                chk("drive_a_timeout", 64'(i), 64'(nb));
                break;
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_a.size() != 0 || exp_c.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 64'(exp_a.size() + exp_c.size()), 64'd0);
    endtask

    task automatic stall_watch();
        int n;
        n = 0;
        while (!a_out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("stall_seen", 64'(a_out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(a_in_ready), 64'd0);
            chk("stall_valid", 64'(a_out_valid), 64'd1);
        end
        rdy_mode = 0;
    endtask

    task automatic fill_ramp();
        for (int l = 0; l < 4; l++) for (int i = 0; i < 16; i++) pix[l][i] = 16'(i);
    endtask

    task automatic fill_rand(input logic [15:0] orv);
        for (int l = 0; l < 4; l++) for (int i = 0; i < 16; i++) pix[l][i] = 16'($urandom) | orv;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        a_out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
    end

    logic        prev_stall = 1'b0;
    logic [63:0] prev_d;
    logic        prev_l;
    logic [64:0] ea;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(a_in_ready), 64'(!a_out_valid | a_out_ready));
            if (prev_stall) begin
                chk("hold_valid", 64'(a_out_valid), 64'd1);
                chk("hold_data", a_out_data, prev_d);
                chk("hold_last", 64'(a_out_last), 64'(prev_l));
            end
            if (a_out_valid && a_out_ready) begin
                if (exp_a.size() == 0) begin
                    chk("unexpected_out_a", a_out_data, 64'hx);
                end else begin
                    ea = exp_a.pop_front();
                    chk("out_data_a", a_out_data, ea[63:0]);
                    chk("out_last_a", 64'(a_out_last), 64'(ea[64]));
                    got_a++;
                end
            end
            prev_stall = a_out_valid & !a_out_ready;
            prev_d     = a_out_data;
            prev_l     = a_out_last;
        end
    end

    logic [64:0] ec;
    initial forever begin
        @(negedge clk);
        if (rst_n && c_out_valid && c_out_ready) begin
            if (exp_c.size() == 0) begin
                chk("unexpected_out_c", 64'(c_out_data), 64'hx);
            end else begin
                ec = exp_c.pop_front();
                chk("out_data_c", 64'(c_out_data), ec[63:0]);
                chk("out_last_c", 64'(c_out_last), 64'(ec[64]));
                got_c++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int guard;
        logic acc;
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b1;
        c_in_valid  = 1'b0;
        c_in_data   = '0;
        c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_last", 64'(a_out_last), 64'd0);
        chk("rst_out_data", a_out_data, 64'd0);
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        chk("rst_c_out_valid", 64'(c_out_valid), 64'd0);
        rst_n = 1'b1;

        // Lane rule windows in lane 0, random data elsewhere
        fill_rand(16'h0000);
        pix[0][0] = 16'h0003; pix[0][1] = 16'h0005; pix[0][4] = 16'h8001; pix[0][5] = 16'h8007;
        pix[0][2] = 16'h8002; pix[0][3] = 16'h8009; pix[0][6] = 16'h800A; pix[0][7] = 16'h8003;
        pix[0][8] = 16'h8000; pix[0][9] = 16'h0000; pix[0][12] = 16'h8000; pix[0][13] = 16'h8000;
        model(4, 4, 2, 4, 1'b0);
        chk("model_rule_pos", 64'(model_out[0][0]), 64'h0005);
        chk("model_rule_neg", 64'(model_out[0][1]), 64'h8002);
        chk("model_rule_zero", 64'(model_out[0][2]), 64'h0000);
        drive_a(16, 0);
        drain("drain_rule");

        // Ramp frame
        fill_ramp();
        base = got_a;
        model(4, 4, 2, 4, 1'b0);
        chk("model_ramp0", 64'(model_out[0][0]), 64'd5);
        chk("model_ramp1", 64'(model_out[1][1]), 64'd7);
        chk("model_ramp2", 64'(model_out[2][2]), 64'd13);
        chk("model_ramp3", 64'(model_out[3][3]), 64'd15);
        chk("model_last_first", 64'(exp_a[0][64]), 64'd0);
        chk("model_last_final", 64'(exp_a[3][64]), 64'd1);
        drive_a(16, 0);
        drain("drain_ramp");
        chk("count_ramp", 64'(got_a - base), 64'd4);

        // Backpressure on the ramp
        base = got_a;
        model(4, 4, 2, 4, 1'b0);
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        fork
            drive_a(16, 0);
            stall_watch();
        join
        drain("drain_stall");
        chk("count_stall", 64'(got_a - base), 64'd4);

        // Three back-to-back frames with input bubbles and random downstream ready
        base = got_a;
        rdy_mode = 1;
        for (int f = 0; f < 3; f++) begin
            fill_rand((f == 1) ? 16'h8000 : 16'h0000);
            model(4, 4, 2, 4, 1'b0);
            drive_a(16, 50);
        end
        rdy_mode = 0;
        drain("drain_bubbles");
        chk("count_bubbles", 64'(got_a - base), 64'd12);

        // Reset after 7 beats of a frame, then a fresh frame
        fill_ramp();
        model(4, 4, 2, 4, 1'b0);
        drive_a(7, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_out_data", a_out_data, 64'd0);
        chk("midrst_in_ready", 64'(a_in_ready), 64'd1);
        exp_a.delete();
        rst_n = 1'b1;
        base = got_a;
        fill_rand(16'h8000);
        model(4, 4, 2, 4, 1'b0);
        drive_a(16, 0);
        drain("drain_after_rst");
        chk("count_after_rst", 64'(got_a - base), 64'd4);

        // POOL=3 on a 6x6 single-lane frame
        for (int i = 0; i < 36; i++) pix[0][i] = 16'h8001;
        for (int w = 0; w < 4; w++) pix[0][(w / 2) * 18 + (w % 2) * 3 + $urandom_range(2) * 6 + $urandom_range(2)] = 16'h0000;
        model(6, 6, 3, 1, 1'b1);
        for (int w = 0; w < 4; w++) chk("model_pool3", 64'(model_out[0][w]), 64'h0000);
        guard = 0;
        for (int i = 0; i < 36 && guard < 500; guard++) begin
            c_in_valid = 1'b1;
            c_in_data  = pix[0][i];
            @(negedge clk);
            acc = c_in_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
        end
        c_in_valid = 1'b0;
        drain("drain_pool3");
        chk("count_pool3", 64'(got_c), 64'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/max_pool_2d.md
# max_pool_2d

Streaming 2-D max-pooling engine for the accelerator's post-convolution path. It accepts a row-major feature map one pixel per beat, with CHANNELS lanes in parallel, and emits one pooled pixel per POOL×POOL window. Window stride equals POOL. Data is sign-magnitude, and the engine applies the team's sign-magnitude max rule per lane. A valid/ready handshake on both sides lets it sit between the convolution output FIFO and the activation writer.

## Interface
- DATA_WIDTH, 16: bits per lane value, sign-magnitude (MSB = sign).
- CHANNELS, 4: parallel lanes per beat.
- POOL, 2: window edge and stride. Must be ≥2.
- IMG_W, 28: input columns. Must be a multiple of POOL.
- IMG_H, 28: input rows. Must be a multiple of POOL.
- clk  in  1  clock. All logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_data  in  CHANNELS*DATA_WIDTH  lane c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  pooled beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  CHANNELS*DATA_WIDTH  pooled lanes, same packing as in_data.
- out_last  out  1  high on the final pooled beat of a frame.

## Operation
- **Lane max rule, applied to each lane:**
  - Both signs 0: the value with the larger magnitude wins.
  - Both signs 1: the value with the smaller magnitude wins.
  - Signs differ: the value with sign 0 wins, so +0 beats −0.
  - Equal bits: either operand may be returned, since they are identical.
- **Counters** are advanced only on an accepted beat (in_valid & in_ready):
  - col: 0..IMG_W-1.
  - row: 0..IMG_H-1.
  - kc = col mod POOL.
  - kr = row mod POOL.
  - idx = col / POOL.
  - col wraps to 0 and increments row. row wraps to 0 at frame end.
- **Horizontal accumulator** hacc, one per lane:
  - kc==0: hacc ← in.
  - Otherwise: hacc ← max(hacc, in).
- **Row buffer** rbuf: IMG_W/POOL entries × CHANNELS lanes. It is touched only on the beat with kc==POOL-1, using h = max(hacc, in), or h = in when POOL==1.
  - kr==0: rbuf[idx] ← h.
  - 0<kr<POOL-1: rbuf[idx] ← max(rbuf[idx], h).
  - kr==POOL-1: the output register loads max(rbuf[idx], h) and out_valid is set. rbuf is not written.
- out_last is loaded high when the emitting beat has row==IMG_H-1 and col==IMG_W-1. Otherwise it is loaded 0.
- **Handshake:**
  - in_ready = !out_valid | out_ready, for every beat including non-emitting ones. This gives a simple, glitch-free stall.
  - out_valid clears on out_valid & out_ready unless a new emission loads in the same cycle.
  - out_data and out_last are held stable while out_valid & !out_ready.

## Timing
- Latency: 1 cycle. out_valid rises the cycle after the completing beat is accepted.
- Throughput: 1 input beat/cycle when out_ready is held high. That gives IMG_W*IMG_H/POOL² output beats per frame.
- Simultaneous out handshake and new emission: the new value is loaded and out_valid stays 1.
- Back-to-back frames need no idle cycles. Row 0 of the next frame overwrites rbuf, because kr==0 writes unconditionally.
- **Reset (rst_n low at a clock edge):**
  - col, row and hacc are cleared to 0.
  - out_valid = 0, out_last = 0, out_data = 0.
  - in_ready is 1 in the first cycle after reset.
  - rbuf is not reset; it is don't-care.
  - Reset mid-frame discards the partial frame. The next accepted beat is pixel (0,0).
- in_data is ignored when in_valid is 0 or in_ready is 0.

## Structure
- Shared package pool_pkg holds:
  - the sign-magnitude max function;
  - the lane slice helper;
  - localparams derived from the parameters: OUT_W = IMG_W/POOL and the counter widths, via $clog2.
- Sub-module sm_max: combinational DATA_WIDTH-wide two-input max per the lane rule. It is instantiated 2×CHANNELS times: once for the horizontal merge and once for the vertical merge.
- rbuf is an inferable register array with one read and one write per cycle, at the same idx.

## Test plan
- **Lane rule (POOL=2, CHANNELS=1):** window {0x0003, 0x0005, 0x8001, 0x8007} → 0x0005. Window {0x8002, 0x8009, 0x800A, 0x8003} → 0x8002. Window {0x8000, 0x0000, 0x8000, 0x8000} → 0x0000.
- **Full frame (IMG_W=IMG_H=4, POOL=2, CHANNELS=4):** ramp pixel=row*4+col in every lane → outputs 5, 7, 13, 15 in order. out_last is high only on 15.
- **Backpressure:** hold out_ready=0 for 5 cycles after the first emission. in_ready drops while out_valid is 1, out_data is held, and there is no loss or duplication. The sequence matches the unstalled run.
- **Bubbles:** in_valid randomly low 50% of cycles over 3 back-to-back frames. The output sequence matches the golden model exactly.
- **Reset mid-frame:** pull rst_n low after 7 beats of frame 1. The next cycle shows out_valid=0. A fresh frame then produces correct results with no stale rbuf data.
- **POOL=3, IMG_W=IMG_H=6:** all inputs 0x8001 except one 0x0000 per window → all outputs 0x0000. 4 beats total.
